// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU, one quotient bit per cycle.
// Produces {remainder, quotient} for HI/LO and holds the pipeline while working.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               annul,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               div_stall
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    // state   | meaning
    // IDLE    | waiting for a DIV/DIVU in EX
    // DIVZERO | divisor was zero, result forced next edge
    // BUSY    | one restoring iteration per cycle
    // DONE    | result valid, ready pulses
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] DIVZERO = 2'd1;
    localparam logic [1:0] BUSY    = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    logic [1:0]       state;
    logic [CW-1:0]    counter;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvsr;
    logic [WIDTH-1:0] dvnd_raw;
    logic             sign_a;
    logic             sign_b;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    always_comb begin
        a_mag = (signed_div && a[WIDTH-1]) ? -a : a;
        b_mag = (signed_div && b[WIDTH-1]) ? -b : b;
        rem_shift = {rem, quo[WIDTH-1]};
        // Partial remainder stays below the divisor, so bit WIDTH of the
        // trial difference is a reliable sign bit.
        trial = rem_shift - {1'b0, dvsr};
        if (trial[WIDTH]) begin
            rem_next = rem_shift[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end else begin
            rem_next = trial[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end
        q_fix = (sign_a ^ sign_b) ? -quo_next : quo_next;
        r_fix = sign_a ? -rem_next : rem_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            counter  <= '0;
            rem      <= '0;
            quo      <= '0;
            dvsr     <= '0;
            dvnd_raw <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            result   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !annul) begin
                        dvnd_raw <= a;
                        sign_a   <= signed_div & a[WIDTH-1];
                        sign_b   <= signed_div & b[WIDTH-1];
                        if (b == '0) begin
                            state <= DIVZERO;
                        end else begin
                            rem     <= '0;
                            quo     <= a_mag;
                            dvsr    <= b_mag;
                            counter <= '0;
                            state   <= BUSY;
                        end
                    end
                end
                DIVZERO: begin
                    if (annul) begin
                        state <= IDLE;
                    end else begin
                        result <= {dvnd_raw, {WIDTH{1'b1}}};
                        state  <= DONE;
                    end
                end
                BUSY: begin
                    if (annul) begin
                        counter <= '0;
                        state   <= IDLE;
                    end else begin
                        rem <= rem_next;
                        quo <= quo_next;
                        // Sign fixup is folded into the final write so result is
                        // already correct during the DONE cycle.
                        if (counter == LAST_ITER) begin
                            counter <= '0;
                            result  <= {r_fix, q_fix};
                            state   <= DONE;
                        end else begin
                            counter <= counter + CW'(1);
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign ready     = (state == DONE);
    assign div_stall = ~rst & (((state == IDLE) & start & ~annul)
                               | (state == BUSY) | (state == DIVZERO));
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: hand-computed quotient/remainder, latency,
// stall length, annul and asynchronous reset behaviour.
module tb_div_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] a;
    logic [31:0] b;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        div_stall;

    int checks = 0;
    int failures = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
        .a(a), .b(b), .annul(annul),
        .result(result), .ready(ready), .div_stall(div_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Called just after an edge; start drops in the ready cycle as the
    // pipeline would advance the instruction.
    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                          input logic ts, input logic [63:0] exp_res,
                          input int exp_lat, input int exp_stall);
        int cyc = 0;
        int st = 0;
        bit got = 0;
        a = ta; b = tb; signed_div = ts; start = 1'b1; annul = 1'b0;
        while (cyc < 60 && !got) begin
            #1;
            if (div_stall) st++;
            if (ready) begin
                got = 1;
                start = 1'b0;
            end else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        chk({tag, "_ready_seen"}, 64'(got), 64'd1);
        chk({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
        chk({tag, "_stall_cycles"}, 64'(st), 64'(exp_stall));
        chk({tag, "_result"}, result, exp_res);
        next_cycle();
        chk({tag, "_ready_single"}, 64'(ready), 64'd0);
        chk({tag, "_stall_after"}, 64'(div_stall), 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; signed_div = 1'b0; a = '0; b = '0; annul = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_result", result, 64'd0);
        chk("reset_ready", 64'(ready), 64'd0);
        chk("reset_stall", 64'(div_stall), 64'd0);
        rst = 1'b0;
        next_cycle();

        run_op("udiv_100_7", 32'd100, 32'd7, 1'b0, {32'h2, 32'hE}, 33, 33);
        run_op("sdiv_m7_2", 32'hFFFF_FFF9, 32'h2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 33);
        run_op("sdiv_7_m2", 32'h7, 32'hFFFF_FFFE, 1'b1, {32'h1, 32'hFFFF_FFFD}, 33, 33);
        run_op("sdiv_m100_m7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, {32'hFFFF_FFFE, 32'hE}, 33, 33);
        run_op("sdiv_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000}, 33, 33);
        run_op("udiv_max_1", 32'hFFFF_FFFF, 32'h1, 1'b0, {32'h0, 32'hFFFF_FFFF}, 33, 33);
        run_op("divzero", 32'h1234_5678, 32'h0, 1'b0, {32'h1234_5678, 32'hFFFF_FFFF}, 2, 2);

        // Annul ten cycles into BUSY: no ready, result unchanged.
        a = 32'd100; b = 32'd7; signed_div = 1'b0; start = 1'b1;
        repeat (10) next_cycle();
        chk("annul_busy_stall", 64'(div_stall), 64'd1);
        annul = 1'b1;
        next_cycle();
        start = 1'b0; annul = 1'b0;
        #1;
        chk("annul_idle_stall", 64'(div_stall), 64'd0);
        begin
            int rdy = 0;
            for (int i = 0; i < 40; i++) begin
                if (ready) rdy++;
                next_cycle();
            end
            chk("annul_no_ready", 64'(rdy), 64'd0);
        end
        chk("annul_result_kept", result, {32'h1234_5678, 32'hFFFF_FFFF});
        run_op("udiv_9_3", 32'd9, 32'd3, 1'b0, {32'h0, 32'h3}, 33, 33);

        // Start and annul together in IDLE: nothing begins.
        a = 32'd50; b = 32'd5; start = 1'b1; annul = 1'b1;
        #1;
        chk("start_annul_stall", 64'(div_stall), 64'd0);
        next_cycle();
        start = 1'b0; annul = 1'b0;
        begin
            int rdy = 0;
            for (int i = 0; i < 5; i++) begin
                #1;
                if (ready || div_stall) rdy++;
                next_cycle();
            end
            chk("start_annul_no_op", 64'(rdy), 64'd0);
        end

        // Asynchronous reset between edges mid-BUSY with start still high.
        a = 32'd1000; b = 32'd3; start = 1'b1;
        repeat (6) next_cycle();
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_result", result, 64'd0);
        chk("async_rst_ready", 64'(ready), 64'd0);
        chk("async_rst_stall", 64'(div_stall), 64'd0);
        start = 1'b0;
        next_cycle();
        rst = 1'b0;
        next_cycle();
        chk("post_rst_idle_stall", 64'(div_stall), 64'd0);
        run_op("post_rst_udiv", 32'd1000, 32'd3, 1'b0, {32'h1, 32'd333}, 33, 33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
